// File: rtl/rand_burst_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rand_pkg
//  Description : Shared types and helpers for the burst randomizer sequencer:
//                FSM state encoding, pad byte value, seed width and the
//                seed-assembly function.
//  Revision    : 1.0 - initial release
// ============================================================================
package rand_pkg;

  localparam int         SEED_W   = 15;
  localparam logic [7:0] PAD_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_DONE = 3'd4
  } rand_ctl_state_t;

  // Seed layout, MSB first: frame[4:0], 1, iuc[3:0], 1, bsid[3:0]
  function automatic logic [SEED_W-1:0] mk_seed(
    input logic [3:0] bsid,
    input logic [3:0] iuc,
    input logic [4:0] frame_num
  );
    return {frame_num, 1'b1, iuc, 1'b1, bsid};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rand_burst_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rand_burst_ctl_if
//  Description : Burst control, payload and randomizer-side signals of the
//                burst sequencer. "master" is the MAC/FEC environment side,
//                "slave" is the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rand_burst_ctl_if #(
  parameter int LEN_W = 12
);
  import rand_pkg::*;

  // burst request
  logic              burst_start;
  logic [LEN_W-1:0]  burst_len;
  logic [LEN_W-1:0]  alloc_len;
  logic [3:0]        bsid;
  logic [3:0]        iuc;
  logic [4:0]        frame_num;
  // payload from MAC FIFO
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  // randomizer / FEC side
  logic              out_ready;
  logic [7:0]        rnd_bits;
  logic              rnd_valid;
  logic [SEED_W-1:0] rnd_iv;
  logic              rnd_reload;
  // status
  logic              busy;
  logic              done;
  logic              len_err;

  modport master (
    output burst_start, burst_len, alloc_len, bsid, iuc, frame_num,
    output in_data, in_valid, out_ready,
    input  in_ready, rnd_bits, rnd_valid, rnd_iv, rnd_reload,
    input  busy, done, len_err
  );

  modport slave (
    input  burst_start, burst_len, alloc_len, bsid, iuc, frame_num,
    input  in_data, in_valid, out_ready,
    output in_ready, rnd_bits, rnd_valid, rnd_iv, rnd_reload,
    output busy, done, len_err
  );

endinterface
`default_nettype wire

// File: rtl/rand_burst_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : rand_burst_cnt
//  Description : Per-burst byte counter. Latches the payload and allocation
//                limits on load, counts emitted bytes, and flags the byte
//                that will complete the payload or the allocation.
//  Revision    : 1.0 - initial release
// ============================================================================
module rand_burst_cnt #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] data_len_i,
  input  logic [LEN_W-1:0] alloc_len_i,
  output logic             data_last_o,
  output logic             alloc_last_o,
  output logic             data_zero_o,
  output logic             alloc_zero_o,
  output logic             pad_more_o
);

  logic [LEN_W-1:0] byte_cnt_q;
  logic [LEN_W-1:0] data_len_q;
  logic [LEN_W-1:0] alloc_len_q;
  logic [LEN_W-1:0] w_cnt_inc;

  // Count cannot wrap: it never passes alloc_len, which fits in LEN_W bits
  assign w_cnt_inc = byte_cnt_q + LEN_W'(1);

  // Limit capture at burst start, count per emitted byte, clear at burst end
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      data_len_q  <= '0;
      alloc_len_q <= '0;
    end else if (load_i) begin
      byte_cnt_q  <= '0;
      data_len_q  <= data_len_i;
      alloc_len_q <= alloc_len_i;
    end else if (clear_i) begin
      byte_cnt_q  <= '0;
      data_len_q  <= '0;
      alloc_len_q <= '0;
    end else if (inc_i) begin
      byte_cnt_q  <= w_cnt_inc;
    end
  end

  // "last" flags: the byte being counted now reaches the limit
  assign data_last_o  = (w_cnt_inc == data_len_q);
  assign alloc_last_o = (w_cnt_inc == alloc_len_q);
  assign data_zero_o  = (data_len_q == '0);
  assign alloc_zero_o = (alloc_len_q == '0);
  // payload is clamped to the allocation, so inequality means padding remains
  assign pad_more_o   = (alloc_len_q != data_len_q);

endmodule
`default_nettype wire

// File: rtl/rand_burst_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : rand_burst_ctl
//  Description : Per-burst sequencer for the byte-wide OFDM randomizer.
//                Builds the 15-bit seed, issues a one-cycle reload, streams
//                payload bytes, then (optionally) pads the allocation with
//                0xFF and pulses done.
//                Build option RAND_BURST_PAD_EN: when defined, padding to
//                alloc_len and len_err reporting are present; when undefined,
//                the burst ends after burst_len bytes and alloc_len is unused.
//  Revision    : 1.0 - initial release
// ============================================================================
module rand_burst_ctl
  import rand_pkg::*;
#(
  parameter int LEN_W     = 12,
  parameter int BITS_PCLK = 8
) (
  input  logic            clk,
  input  logic            reset,
  rand_burst_ctl_if.slave bus
);

  rand_ctl_state_t      state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 len_err_q;
  logic                 rnd_reload_q;
  logic                 rnd_valid_q;
  logic [BITS_PCLK-1:0] rnd_bits_q;
  logic [SEED_W-1:0]    rnd_iv_q;

  logic                 w_start;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_pad_emit;
  logic                 w_inc;
  logic                 w_clear;
  logic                 w_len_over;
  logic [LEN_W-1:0]     w_data_len;
  logic [LEN_W-1:0]     w_alloc_len;
  logic                 w_data_last;
  logic                 w_alloc_last;
  logic                 w_data_zero;
  logic                 w_alloc_zero;
  logic                 w_pad_more;

  assign w_start    = (state_q == ST_IDLE) && bus.burst_start;
  assign w_in_ready = (state_q == ST_DATA) && bus.out_ready;
  assign w_accept   = w_in_ready && bus.in_valid;
  assign w_inc      = w_accept || w_pad_emit;
  assign w_clear    = (state_q == ST_DONE);

`ifdef RAND_BURST_PAD_EN
  // Oversized payload is clamped to the allocation and flagged
  assign w_len_over  = (bus.burst_len > bus.alloc_len);
  assign w_data_len  = w_len_over ? bus.alloc_len : bus.burst_len;
  assign w_alloc_len = bus.alloc_len;
  assign w_pad_emit  = (state_q == ST_PAD) && bus.out_ready;
`else
  logic w_unused_pad;
  // Allocation plays no part: the burst is exactly the payload
  assign w_len_over   = 1'b0;
  assign w_data_len   = bus.burst_len;
  assign w_alloc_len  = bus.burst_len;
  assign w_pad_emit   = 1'b0;
  assign w_unused_pad = ^{bus.alloc_len, w_alloc_last, w_alloc_zero, w_pad_more};
`endif

  rand_burst_cnt #(
    .LEN_W (LEN_W)
  ) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .load_i       (w_start),
    .clear_i      (w_clear),
    .inc_i        (w_inc),
    .data_len_i   (w_data_len),
    .alloc_len_i  (w_alloc_len),
    .data_last_o  (w_data_last),
    .alloc_last_o (w_alloc_last),
    .data_zero_o  (w_data_zero),
    .alloc_zero_o (w_alloc_zero),
    .pad_more_o   (w_pad_more)
  );

  // Burst FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      len_err_q    <= 1'b0;
      rnd_reload_q <= 1'b0;
      rnd_valid_q  <= 1'b0;
      rnd_bits_q   <= '0;
      rnd_iv_q     <= '0;
    end else begin
      done_q       <= 1'b0;
      len_err_q    <= 1'b0;
      rnd_reload_q <= 1'b0;
      rnd_valid_q  <= 1'b0;
      rnd_bits_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.burst_start) begin
            // reload and seed become visible together during LOAD
            busy_q       <= 1'b1;
            rnd_reload_q <= 1'b1;
            rnd_iv_q     <= mk_seed(bus.bsid, bus.iuc, bus.frame_num);
            len_err_q    <= w_len_over;
            state_q      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!w_data_zero) begin
            state_q <= ST_DATA;
          end
`ifdef RAND_BURST_PAD_EN
          else if (!w_alloc_zero) begin
            state_q <= ST_PAD;
          end
`endif
          else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            rnd_valid_q <= 1'b1;
            rnd_bits_q  <= bus.in_data;
            if (w_data_last) begin
`ifdef RAND_BURST_PAD_EN
              if (w_pad_more) begin
                state_q <= ST_PAD;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
`else
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
`endif
            end
          end
        end
`ifdef RAND_BURST_PAD_EN
        ST_PAD: begin
          if (bus.out_ready) begin
            rnd_valid_q <= 1'b1;
            rnd_bits_q  <= PAD_BYTE;
            if (w_alloc_last) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
`endif
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.rnd_bits   = rnd_bits_q;
  assign bus.rnd_valid  = rnd_valid_q;
  assign bus.rnd_iv     = rnd_iv_q;
  assign bus.rnd_reload = rnd_reload_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.len_err    = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rand_burst_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rand_burst_ctl
//  Description : Self-checking bench for rand_burst_ctl. A table of bursts
//                with hand-computed seeds and word counts is played through
//                the sequencer; hand-written sequences cover the ignored
//                restart and the mid-burst reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rand_burst_ctl;

`ifdef RAND_BURST_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk;
  logic reset;

  rand_burst_ctl_if #(.LEN_W(12)) bus ();

  rand_burst_ctl #(
    .LEN_W     (12),
    .BITS_PCLK (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  bsid;
    logic [3:0]  iuc;
    logic [4:0]  fn;
    logic [11:0] blen;
    logic [11:0] alen;
    bit          toggle;
    logic [7:0]  dbase;
    logic [14:0] exp_iv;
    int          exp_pay_pad;
    int          exp_words_pad;
    int          exp_le_pad;
    int          exp_words_nop;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int          exp_words;
    int          exp_pay;
    int          exp_le;
    int          n_reload = 0;
    int          n_le = 0;
    int          n_done = 0;
    int          overlap = 0;
    int          ready_viol = 0;
    int          stall_viol = 0;
    int          busy_viol = 0;
    int          extra = 0;
    int          idx = 0;
    bit          prev_rdy;
    bit          valid_at_done = 1'b0;
    logic [14:0] iv_seen = '0;
    logic [7:0]  got[$];
    logic [7:0]  exp_b;

    exp_words = PAD ? v.exp_words_pad : v.exp_words_nop;
    exp_pay   = PAD ? v.exp_pay_pad   : v.exp_words_nop;
    exp_le    = PAD ? v.exp_le_pad    : 0;

    @(negedge clk);
    bus.burst_start = 1'b1;
    bus.bsid        = v.bsid;
    bus.iuc         = v.iuc;
    bus.frame_num   = v.fn;
    bus.burst_len   = v.blen;
    bus.alloc_len   = v.alen;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = v.dbase;
    prev_rdy        = 1'b1;
    @(negedge clk);
    bus.burst_start = 1'b0;

    for (int cyc = 0; cyc < 200 && n_done == 0; cyc++) begin
      if (bus.rnd_reload) begin
        n_reload++;
        iv_seen = bus.rnd_iv;
        if (bus.rnd_valid) overlap++;
      end
      if (bus.len_err) n_le++;
      if (bus.rnd_valid) begin
        got.push_back(bus.rnd_bits);
        if (!prev_rdy) stall_viol++;
      end
      if (bus.done) begin
        n_done++;
        if (bus.busy) busy_viol++;
        valid_at_done = bus.rnd_valid;
      end
      bus.out_ready = v.toggle ? ((cyc % 2) == 1) : 1'b1;
      bus.in_data   = v.dbase + 8'(idx);
      #1;
      if (bus.in_ready && !bus.out_ready) ready_viol++;
      if (bus.in_ready && bus.in_valid) idx++;
      prev_rdy = bus.out_ready;
      @(negedge clk);
    end

    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (bus.rnd_valid || bus.done || bus.rnd_reload) extra++;
      @(negedge clk);
    end

    check("done_count", n_done, 1);
    check("reload_count", n_reload, 1);
    check("reload_iv", {17'd0, iv_seen}, {17'd0, v.exp_iv});
    check("reload_valid_overlap", overlap, 0);
    check("len_err_count", n_le, exp_le);
    check("word_count", got.size(), exp_words);
    check("bytes_taken", idx, exp_pay);
    for (int i = 0; i < got.size() && i < exp_words; i++) begin
      exp_b = (i < exp_pay) ? (v.dbase + 8'(i)) : 8'hFF;
      check("word_value", {24'd0, got[i]}, {24'd0, exp_b});
    end
    check("busy_at_done", busy_viol, 0);
    check("last_word_with_done", {31'd0, valid_at_done}, (exp_words > 0) ? 1 : 0);
    check("in_ready_gated", ready_viol, 0);
    check("emit_while_stalled", stall_viol, 0);
    check("activity_after_done", extra, 0);
    check("iv_hold", {17'd0, bus.rnd_iv}, {17'd0, v.exp_iv});
  endtask

  // Ignored restart during DATA, then reset after two of four bytes
  task automatic run_restart_reset();
    int idx = 0;
    int n_le = 0;
    int n_reload = 0;
    int n_bad_after = 0;
    bit sent = 1'b0;

    @(negedge clk);
    bus.burst_start = 1'b1;
    bus.bsid        = 4'h5;
    bus.iuc         = 4'h3;
    bus.frame_num   = 5'h11;
    bus.burst_len   = 12'd4;
    bus.alloc_len   = 12'd6;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = 8'h10;
    @(negedge clk);
    bus.burst_start = 1'b0;

    for (int cyc = 0; cyc < 40 && idx < 2; cyc++) begin
      if (bus.len_err) n_le++;
      if (bus.rnd_reload) n_reload++;
      bus.in_data = 8'h10 + 8'(idx);
      if (idx == 1 && !sent) begin
        bus.burst_start = 1'b1;
        bus.bsid        = 4'hA;
        bus.burst_len   = 12'd10;
        bus.alloc_len   = 12'd2;
        sent            = 1'b1;
      end else begin
        bus.burst_start = 1'b0;
      end
      #1;
      if (bus.in_ready && bus.in_valid) idx++;
      @(negedge clk);
    end
    bus.burst_start = 1'b0;
    if (bus.len_err) n_le++;
    if (bus.rnd_reload) n_reload++;

    check("restart_bytes_taken", idx, 2);
    check("restart_second_byte", {23'd0, bus.rnd_valid, bus.rnd_bits}, {23'd0, 1'b1, 8'h11});
    check("restart_iv_kept", {17'd0, bus.rnd_iv}, 32'h4675);
    check("restart_busy", {31'd0, bus.busy}, 1);
    check("restart_no_len_err", n_le, 0);
    check("restart_one_reload", n_reload, 1);

    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs",
          {5'd0, bus.in_ready, bus.rnd_valid, bus.rnd_reload, bus.busy, bus.done,
           bus.len_err, bus.rnd_bits, bus.rnd_iv},
          32'd0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done || bus.rnd_valid || bus.busy || bus.in_ready) n_bad_after++;
    end
    check("midreset_quiet", n_bad_after, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            bsid  iuc   fn     blen    alen   tog   base   iv       pay w  le nop
    vecs[0] = '{4'h5, 4'h3, 5'h11, 12'd4,  12'd6, 1'b0, 8'h01, 15'h4675, 4, 6, 0, 4};
    vecs[1] = '{4'h5, 4'h3, 5'h11, 12'd4,  12'd6, 1'b1, 8'h01, 15'h4675, 4, 6, 0, 4};
    vecs[2] = '{4'hA, 4'hC, 5'h1F, 12'd0,  12'd3, 1'b0, 8'h00, 15'h7F9A, 0, 3, 0, 0};
    vecs[3] = '{4'h0, 4'h0, 5'h00, 12'd0,  12'd0, 1'b0, 8'h00, 15'h0210, 0, 0, 0, 0};
    vecs[4] = '{4'hF, 4'hF, 5'h00, 12'd10, 12'd8, 1'b0, 8'h40, 15'h03FF, 8, 8, 1, 10};
    vecs[5] = '{4'h1, 4'h2, 5'h01, 12'd3,  12'd3, 1'b1, 8'hE0, 15'h0651, 3, 3, 0, 3};

    reset           = 1'b1;
    bus.burst_start = 1'b0;
    bus.burst_len   = '0;
    bus.alloc_len   = '0;
    bus.bsid        = '0;
    bus.iuc         = '0;
    bus.frame_num   = '0;
    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {5'd0, bus.in_ready, bus.rnd_valid, bus.rnd_reload, bus.busy, bus.done,
           bus.len_err, bus.rnd_bits, bus.rnd_iv},
          32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i]);
    end

    run_restart_reset();
    run_burst(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
